// File: rtl/mux8_rr_scheduler.sv
// Round-robin arbiter for a shared 8:1 mux path. One requester owns the path per grant;
// a grant ends on done, on its request dropping, or after MAX_HOLD cycles.
module mux8_rr_scheduler #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  input  logic [7:0] d,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       y,
  output logic       tout
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic       tout_q, tout_d;
  logic [7:0] hold_q, hold_d;

  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  pick_off;
  logic [2:0]  pick;
  logic        keep;
  logic        timeout;

  // Rotate requests so bit 0 is the current highest-priority index.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_q +: 8];

  always_comb begin
    pick_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 3'(i);
    end
  end

  assign pick    = ptr_q + pick_off;
  assign keep    = req[sel_q] & ~done;
  assign timeout = (hold_q == HoldLast);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    tout_d  = 1'b0;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        gnt_d   = 8'h00;
        valid_d = 1'b0;
        if (req != 8'h00) begin
          sel_d   = pick;
          gnt_d   = 8'h01 << pick;
          valid_d = 1'b1;
          hold_d  = 8'h00;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!keep || timeout) begin
          gnt_d   = 8'h00;
          valid_d = 1'b0;
          ptr_d   = sel_q + 3'd1;
          // Timeout flag only when the grantee still wanted the path.
          tout_d  = keep;
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      gnt_q   <= 8'h00;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      hold_q  <= hold_d;
    end
  end

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign tout  = tout_q;
  assign y     = valid_q ? d[sel_q] : 1'b0;

endmodule
